// File: rtl/controller_sequencer_v2.sv
// controller_sequencer_v2
// Controller/sequencer for a SAP-1 style datapath. A T-state counter steps
// T1..T(TMAX). The SAP control word is decoded combinationally from the
// current T-state, the opcode and the Z/C flags.
// This version adds JMP/JZ/JC, a latching HLT, RUN gating at instruction
// boundaries and idle padding T-states.
//
// Build option: define SEQ_SKIP_IDLE_EN to end each instruction right after
// its last active T-state. With the macro undefined, every instruction runs
// the full T1..T(TMAX), which gives fixed-length, SAP-1 compatible timing.
//
// Handshake: there is no valid/ready pair. RUN is a level. It is looked at only
// at an instruction boundary (last T-state or HOLD) and is ignored in the
// middle of an instruction, so an instruction is never cut short.
//
// Timing: all state changes on the falling edge of CLK. CLR is synchronous and
// has priority over everything else, including HALTED and HOLD.
module controller_sequencer_v2 #(
  parameter int OPW  = 4,
  parameter int TMAX = 6,
  parameter int TW   = 3
) (
  input  logic           CLK,
  input  logic           CLR,
  input  logic [OPW-1:0] opcode,
  input  logic           Z_FLAG,
  input  logic           C_FLAG,
  input  logic           RUN,
  // active-high controls
  output logic           Cp,
  output logic           Ep,
  output logic           EA,
  output logic           SU,
  output logic           EU,
  // active-low controls
  output logic           LM,
  output logic           CE,
  output logic           L1,
  output logic           E1,
  output logic           LA,
  output logic           LB,
  output logic           LO,
  output logic           LP,
  // observable sequencer state
  output logic [TW-1:0]  T_STATE,
  output logic           HALTED
);

  // T-state codes: 0..TMAX-1 stand for T1..T(TMAX), and TMAX is HOLD
  localparam logic [TW-1:0] T1_C   = TW'(0);
  localparam logic [TW-1:0] T2_C   = TW'(1);
  localparam logic [TW-1:0] T3_C   = TW'(2);
  localparam logic [TW-1:0] T4_C   = TW'(3);
  localparam logic [TW-1:0] T5_C   = TW'(4);
  localparam logic [TW-1:0] T6_C   = TW'(5);
  localparam logic [TW-1:0] TL_C   = TW'(TMAX - 1);
  localparam logic [TW-1:0] HOLD_C = TW'(TMAX);

  typedef enum logic [3:0] {
    INS_LDA,
    INS_ADD,
    INS_SUB,
    INS_JMP,
    INS_JZ,
    INS_JC,
    INS_OUT,
    INS_HLT,
    INS_NOP
  } ins_e;

  logic [TW-1:0] t_state;
  logic [TW-1:0] t_next;
  logic          halted;
  logic          halted_next;
  logic          op_hi_nz;
  ins_e          ins;
  logic [TW-1:0] last_t;
  logic          jump_taken;

  // Bits above the 4-bit SAP opcode field force a NOP when any of them is set
  generate
    if (OPW > 4) begin : g_wide_op
      assign op_hi_nz = |opcode[OPW-1:4];
    end else begin : g_narrow_op
      assign op_hi_nz = 1'b0;
    end
  endgenerate

  // Decode the opcode into an instruction class
  always_comb begin
    ins = INS_NOP;
    if (!op_hi_nz) begin
      case (opcode[3:0])
        4'b0000: ins = INS_LDA;
        4'b0001: ins = INS_ADD;
        4'b0010: ins = INS_SUB;
        4'b0011: ins = INS_JMP;
        4'b0100: ins = INS_JZ;
        4'b0101: ins = INS_JC;
        4'b1110: ins = INS_OUT;
        4'b1111: ins = INS_HLT;
        default: ins = INS_NOP;
      endcase
    end
  end

  // Last T-state of the current instruction (its boundary)
  always_comb begin
`ifdef SEQ_SKIP_IDLE_EN
    case (ins)
      INS_LDA:          last_t = T5_C;
      INS_ADD, INS_SUB: last_t = T6_C;
      INS_HLT:          last_t = TL_C;
      default:          last_t = T4_C;
    endcase
`else
    last_t = TL_C;
`endif
  end

  // A branch is taken when the instruction is JMP, or JZ/JC with its flag set.
  // The result is only used in T4.
  always_comb begin
    jump_taken = 1'b0;
    case (ins)
      INS_JMP: jump_taken = 1'b1;
      INS_JZ:  jump_taken = Z_FLAG;
      INS_JC:  jump_taken = C_FLAG;
      default: jump_taken = 1'b0;
    endcase
  end

  // State register: falling edge, synchronous CLR has top priority
  always_ff @(negedge CLK) begin
    if (CLR) begin
      t_state <= T1_C;
      halted  <= 1'b0;
    end else begin
      t_state <= t_next;
      halted  <= halted_next;
    end
  end

  // Next state. HALTED freezes everything. HLT latches in T4. The boundary
  // goes to T1 or HOLD depending on RUN.
  always_comb begin
    t_next      = t_state;
    halted_next = halted;
    if (halted) begin
      t_next = t_state;
    end else if (t_state == HOLD_C) begin
      if (RUN) t_next = T1_C;
    end else if ((t_state == T4_C) && (ins == INS_HLT)) begin
      halted_next = 1'b1;
    end else if (t_state >= last_t) begin
      t_next = RUN ? T1_C : HOLD_C;
    end else begin
      t_next = t_state + TW'(1);
    end
  end

  // Control word. Every signal starts idle, and only the listed steps drive an
  // active level. HOLD, HALTED and the padding T-states stay idle.
  always_comb begin
    Cp = 1'b0; Ep = 1'b0; EA = 1'b0; SU = 1'b0; EU = 1'b0;
    LM = 1'b1; CE = 1'b1; L1 = 1'b1; E1 = 1'b1;
    LA = 1'b1; LB = 1'b1; LO = 1'b1; LP = 1'b1;
    if (!halted) begin
      case (t_state)
        T1_C: begin
          Ep = 1'b1;
          LM = 1'b0;
        end
        T2_C: begin
          Cp = 1'b1;
        end
        T3_C: begin
          CE = 1'b0;
          L1 = 1'b0;
        end
        T4_C: begin
          case (ins)
            INS_LDA, INS_ADD, INS_SUB: begin
              E1 = 1'b0;
              LM = 1'b0;
            end
            INS_JMP, INS_JZ, INS_JC: begin
              if (jump_taken) begin
                E1 = 1'b0;
                LP = 1'b0;
              end
            end
            INS_OUT: begin
              EA = 1'b1;
              LO = 1'b0;
            end
            default: ;
          endcase
        end
        T5_C: begin
          case (ins)
            INS_LDA: begin
              CE = 1'b0;
              LA = 1'b0;
            end
            INS_ADD, INS_SUB: begin
              CE = 1'b0;
              LB = 1'b0;
            end
            default: ;
          endcase
        end
        T6_C: begin
          if ((ins == INS_ADD) || (ins == INS_SUB)) begin
            EU = 1'b1;
            LA = 1'b0;
            SU = (ins == INS_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign T_STATE = t_state;
  assign HALTED  = halted;

endmodule

// File: tb/tb_controller_sequencer_v2.sv
// Testbench for controller_sequencer_v2 (OPW=4, TMAX=6, TW=3).
// The reference model is written in terms of instructions. It tracks which
// T-step of which instruction is current, and it builds the expected control
// word from the instruction table.
// Compile with SEQ_SKIP_IDLE_EN defined to test the skip-idle build.
module tb_controller_sequencer_v2;

  localparam int TMAX = 6;

  logic       CLK;
  logic       CLR;
  logic [3:0] opcode;
  logic       Z_FLAG;
  logic       C_FLAG;
  logic       RUN;
  logic       Cp, Ep, EA, SU, EU, LM, CE, L1, E1, LA, LB, LO, LP;
  logic [2:0] T_STATE;
  logic       HALTED;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: step index within instruction (TMAX = parked)
  int m_t = 0;
  bit m_h = 1'b0;

  controller_sequencer_v2 #(.OPW(4), .TMAX(TMAX), .TW(3)) dut (
    .CLK(CLK), .CLR(CLR), .opcode(opcode), .Z_FLAG(Z_FLAG), .C_FLAG(C_FLAG),
    .RUN(RUN),
    .Cp(Cp), .Ep(Ep), .EA(EA), .SU(SU), .EU(EU),
    .LM(LM), .CE(CE), .L1(L1), .E1(E1), .LA(LA), .LB(LB), .LO(LO), .LP(LP),
    .T_STATE(T_STATE), .HALTED(HALTED)
  );

  // clock: DUT acts on negedge; bench drives and samples just after posedge
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // number of T-states an instruction occupies
  function automatic int instr_len(input logic [3:0] op);
`ifdef SEQ_SKIP_IDLE_EN
    case (op)
      4'd0:       return 5;
      4'd1, 4'd2: return 6;
      4'd15:      return TMAX;
      default:    return 4;
    endcase
`else
    return TMAX;
`endif
  endfunction

  // expected {Cp,Ep,EA,SU,EU,LM,CE,L1,E1,LA,LB,LO,LP} from the instruction table
  function automatic logic [12:0] exp_word(input int t, input bit h,
                                           input logic [3:0] op,
                                           input logic z, input logic c);
    logic cp, ep, ea, su, eu, lm, ce, l1, e1, la, lb, lo, lp;
    cp = 0; ep = 0; ea = 0; su = 0; eu = 0;
    lm = 1; ce = 1; l1 = 1; e1 = 1; la = 1; lb = 1; lo = 1; lp = 1;
    if (!h && t < TMAX) begin
      if (t == 0) begin ep = 1; lm = 0; end
      if (t == 1) cp = 1;
      if (t == 2) begin ce = 0; l1 = 0; end
      if (t == 3) begin
        if (op <= 4'd2) begin e1 = 0; lm = 0; end
        if (op == 4'd3 || (op == 4'd4 && z) || (op == 4'd5 && c)) begin
          e1 = 0; lp = 0;
        end
        if (op == 4'd14) begin ea = 1; lo = 0; end
      end
      if (t == 4) begin
        if (op == 4'd0) begin ce = 0; la = 0; end
        if (op == 4'd1 || op == 4'd2) begin ce = 0; lb = 0; end
      end
      if (t == 5 && (op == 4'd1 || op == 4'd2)) begin
        eu = 1; la = 0; su = (op == 4'd2);
      end
    end
    return {cp, ep, ea, su, eu, lm, ce, l1, e1, la, lb, lo, lp};
  endfunction

  // what the next falling edge does to the model
  task automatic model_advance(input logic clr, input logic run, input logic [3:0] op);
    if (clr) begin
      m_t = 0; m_h = 0;
    end else if (m_h) begin
      m_t = m_t;
    end else if (m_t == TMAX) begin
      if (run) m_t = 0;
    end else if (m_t == 3 && op == 4'd15) begin
      m_h = 1;
    end else if (m_t >= instr_len(op) - 1) begin
      m_t = run ? 0 : TMAX;
    end else begin
      m_t = m_t + 1;
    end
  endtask

  // one clock: drive inputs after posedge, check outputs, then advance the model
  task automatic step(input logic clr, input logic run, input logic [3:0] op,
                      input logic z, input logic c, input bit chk);
    logic [12:0] obs_w, exp_w;
    @(posedge CLK);
    CLR = clr; RUN = run; opcode = op; Z_FLAG = z; C_FLAG = c;
    #1;
    if (chk) begin
      obs_w = {Cp, Ep, EA, SU, EU, LM, CE, L1, E1, LA, LB, LO, LP};
      exp_w = exp_word(m_t, m_h, op, z, c);
      n_checks++;
      assert (T_STATE === 3'(m_t)) else begin
        n_fail++;
        $error("FAIL t_state op=%0d obs=%0d exp=%0d", op, T_STATE, m_t);
      end
      n_checks++;
      assert (HALTED === m_h) else begin
        n_fail++;
        $error("FAIL halted op=%0d obs=%0b exp=%0b", op, HALTED, m_h);
      end
      n_checks++;
      assert (obs_w === exp_w) else begin
        n_fail++;
        $error("FAIL ctrl_word op=%0d t=%0d obs=%013b exp=%013b", op, m_t, obs_w, exp_w);
      end
    end
    model_advance(clr, run, op);
  endtask

  task automatic do_reset(input logic [3:0] op);
    step(1'b1, 1'b1, op, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] cur_op;
    logic       r_run;
    CLR = 1'b1; RUN = 1'b1; opcode = 4'd0; Z_FLAG = 1'b0; C_FLAG = 1'b0;

    // reset state: T1 word, not halted
    do_reset(4'd1);
    // ADD: full instruction then wrap to T1
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
    // SUB
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
    // JZ untaken then taken, flags wiggle after T4
    do_reset(4'd4);
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b1, 4'd4, (i >= 6 && i != 3) ? 1'($urandom) : 1'b0, 1'b0, 1'b1);
    do_reset(4'd4);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 4'd4, (i == 3) ? 1'b1 : 1'($urandom), 1'b0, 1'b1);
    // JC taken and JMP
    do_reset(4'd5);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    // OUT instruction length
    do_reset(4'd14);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 4'd14, 1'b0, 1'b0, 1'b1);
    // LDA with RUN dropped in T3: finishes, parks in HOLD, restarts on RUN
    do_reset(4'd0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < TMAX + 4; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    // HLT: latches at T4, frozen for 20 clocks, CLR releases
    do_reset(4'd15);
    for (int i = 0; i < 4 + 20; i++) step(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
    // CLR mid-instruction
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);

    // random run: opcode stays fixed within an instruction, as the IR would hold it
    cur_op = 4'd0;
    for (int i = 0; i < 600; i++) begin
      if (m_t == 0 || m_t == TMAX) begin
        cur_op = 4'($urandom_range(0, 15));
        if (cur_op == 4'd15 && $urandom_range(0, 3) != 0) cur_op = 4'd14;
      end
      r_run = ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 49) == 0), r_run, cur_op,
           1'($urandom), 1'($urandom), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
